// File: rtl/mux_display_bcd_n.sv
// N-digit BCD up/down counter with parallel load, driving a multiplexed
// 7-segment display with leading-zero blanking and one-clock anode dead-time.
module mux_display_bcd_n #(
  parameter int N_DIGITS         = 4,
  parameter int TICK_DIV         = 100000000,
  parameter int REFRESH_DIV      = 100000,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  count_en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_value,
  input  logic                  blank_lz,
  output logic [4*N_DIGITS-1:0] bcd_value,
  output logic                  wrap,
  output logic [N_DIGITS-1:0]   Anode_Activate,
  output logic [6:0]            LED_out
);

  localparam int W  = 4 * N_DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST    = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [RW-1:0]       refresh_cnt;
  logic                refresh_wrap;
  logic [IW-1:0]       digit_idx;
  logic [W-1:0]        load_clamped;
  logic [W-1:0]        inc_value;
  logic [W-1:0]        dec_value;
  logic                inc_carry;
  logic                dec_borrow;
  int                  sel_pos;
  logic [3:0]          sel_digit;
  logic                upper_zero;
  logic                blank_digit;
  logic [6:0]          seg_lit;
  logic [6:0]          seg_next;
  logic [N_DIGITS-1:0] anode_next;

  // Segment patterns in active-low form (bit6 = a ... bit0 = g).
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign tick         = (tick_cnt == TICK_LAST);
  assign refresh_wrap = (refresh_cnt == REFRESH_LAST);

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_comb begin
    load_clamped = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      load_clamped[4*d +: 4] = (load_value[4*d +: 4] > 4'd9) ? 4'd9 : load_value[4*d +: 4];
    end
  end

  // Ripple carry across digits; the carry left over out of the top digit is the wrap.
  always_comb begin
    inc_value = bcd_value;
    inc_carry = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (inc_carry) begin
        if (bcd_value[4*d +: 4] == 4'd9) begin
          inc_value[4*d +: 4] = 4'd0;
        end else begin
          inc_value[4*d +: 4] = bcd_value[4*d +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dec_value  = bcd_value;
    dec_borrow = 1'b1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (dec_borrow) begin
        if (bcd_value[4*d +: 4] == 4'd0) begin
          dec_value[4*d +: 4] = 4'd9;
        end else begin
          dec_value[4*d +: 4] = bcd_value[4*d +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      bcd_value <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      bcd_value <= load_clamped;
      wrap      <= 1'b0;
    end else if (tick && count_en) begin
      bcd_value <= up_down ? inc_value : dec_value;
      wrap      <= up_down ? inc_carry : dec_borrow;
    end else begin
      wrap <= 1'b0;
    end
  end

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_wrap) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Index 0 is the most significant digit, which sits on the top anode bit.
  always_comb begin
    sel_pos    = N_DIGITS - 1 - int'(digit_idx);
    sel_digit  = bcd_value[4*sel_pos +: 4];
    upper_zero = 1'b1;
    for (int p = 0; p < N_DIGITS; p++) begin
      if (p >= sel_pos && bcd_value[4*p +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    blank_digit = blank_lz && (sel_pos != 0) && upper_zero;
    anode_next  = (ANODE_ACTIVE_LOW != 0) ? ~(N_DIGITS'(1) << sel_pos)
                                          :  (N_DIGITS'(1) << sel_pos);
    seg_lit     = seg_pattern(sel_digit);
    seg_next    = (SEG_ACTIVE_LOW != 0) ? seg_lit : ~seg_lit;
  end

  // The clock in which the index advances drives everything off (dead-time).
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      Anode_Activate <= ANODE_OFF;
      LED_out        <= SEG_OFF;
    end else if (refresh_wrap) begin
      Anode_Activate <= ANODE_OFF;
      LED_out        <= SEG_OFF;
    end else begin
      Anode_Activate <= anode_next;
      LED_out        <= blank_digit ? SEG_OFF : seg_next;
    end
  end

endmodule

// File: tb/tb_mux_display_bcd_n.sv
// Self-checking bench for mux_display_bcd_n (N=4, short tick/refresh periods)
// against a decimal-arithmetic reference model.
module tb_mux_display_bcd_n;

  localparam int N    = 4;
  localparam int TDIV = 4;
  localparam int RDIV = 3;
  localparam int MAXV = 10000;
  localparam int SLOT = RDIV * N;

  localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010,
    7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000,
    7'b0000100};
  localparam logic [3:0] EXP_AN  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [6:0] EXP_LED [4] = '{7'h7F, 7'h7F, 7'b1001100, 7'b0010010};

  logic        clk;
  logic        reset;
  logic        count_en;
  logic        up_down;
  logic        load;
  logic [15:0] load_value;
  logic        blank_lz;
  logic [15:0] bcd_value;
  logic        wrap;
  logic [3:0]  anode;
  logic [6:0]  led;

  int n_checks;
  int n_fail;

  int         m_edges;
  int         m_val;
  logic       m_wrap;
  logic [3:0] m_anode;
  logic [6:0] m_led;

  mux_display_bcd_n #(
    .N_DIGITS(N), .TICK_DIV(TDIV), .REFRESH_DIV(RDIV),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clock_100Mhz(clk), .reset(reset), .count_en(count_en), .up_down(up_down),
    .load(load), .load_value(load_value), .blank_lz(blank_lz),
    .bcd_value(bcd_value), .wrap(wrap), .Anode_Activate(anode), .LED_out(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < N; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  // k = number of clock edges since reset release, counted at the edge itself.
  function automatic logic [3:0] exp_anode(input int k);
    if (k % RDIV == 0) return 4'b1111;
    return ~(4'(1) << (N - 1 - (k / RDIV) % N));
  endfunction

  function automatic logic [6:0] exp_led(input int k, input int v, input logic blz);
    int pos;
    if (k % RDIV == 0) return 7'h7F;
    pos = N - 1 - (k / RDIV) % N;
    if (blz && pos != 0 && v < 10 ** pos) return 7'h7F;
    return SEG_TAB[(v / (10 ** pos)) % 10];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edges <= 0;
      m_val   <= 0;
      m_wrap  <= 1'b0;
      m_anode <= 4'b1111;
      m_led   <= 7'h7F;
    end else begin
      m_edges <= m_edges + 1;
      m_anode <= exp_anode(m_edges + 1);
      m_led   <= exp_led(m_edges + 1, m_val, blank_lz);
      if (load) begin
        m_val  <= from_load(load_value);
        m_wrap <= 1'b0;
      end else if (((m_edges + 1) % TDIV) == 0 && count_en) begin
        if (up_down) begin
          m_val  <= (m_val + 1) % MAXV;
          m_wrap <= (m_val == MAXV - 1);
        end else begin
          m_val  <= (m_val + MAXV - 1) % MAXV;
          m_wrap <= (m_val == 0);
        end
      end else begin
        m_wrap <= 1'b0;
      end
    end
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    load       = 1'b1;
    load_value = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (anode !== 4'b1111) begin n_fail++; $display("[TB] FAIL reset_anode: got %b expected %b", anode, 4'b1111); end
    n_checks++;
    if (led !== 7'h7F) begin n_fail++; $display("[TB] FAIL reset_led: got %b expected %b", led, 7'h7F); end
    n_checks++;
    if (bcd_value !== 16'h0000 || wrap !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_value: got %h/%b expected 0000/0", bcd_value, wrap);
    end
  endtask

  task automatic test_count_up();
    count_en = 1'b1;
    up_down  = 1'b1;
    reset    = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bcd_value !== 16'h0001) begin n_fail++; $display("[TB] FAIL count_4clk: got %h expected 0001", bcd_value); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bcd_value !== 16'h0002) begin n_fail++; $display("[TB] FAIL count_8clk: got %h expected 0002", bcd_value); end
  endtask

  task automatic test_carry_wrap();
    int n;
    up_down = 1'b1;
    do_load(16'h0999);
    n = 0;
    while (bcd_value == 16'h0999 && n < 3 * TDIV) begin @(negedge clk); n++; end
    n_checks++;
    if (bcd_value !== 16'h1000 || wrap !== 1'b0) begin
      n_fail++; $display("[TB] FAIL carry_0999: got %h/%b expected 1000/0", bcd_value, wrap);
    end
    do_load(16'h9999);
    n = 0;
    while (bcd_value == 16'h9999 && n < 3 * TDIV) begin @(negedge clk); n++; end
    n_checks++;
    if (bcd_value !== 16'h0000 || wrap !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wrap_up: got %h/%b expected 0000/1", bcd_value, wrap);
    end
    @(negedge clk);
    n_checks++;
    if (wrap !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_up_width: got %b expected 0", wrap); end
  endtask

  task automatic test_borrow();
    int n;
    up_down = 1'b0;
    do_load(16'h0000);
    n = 0;
    while (bcd_value == 16'h0000 && n < 3 * TDIV) begin @(negedge clk); n++; end
    n_checks++;
    if (bcd_value !== 16'h9999 || wrap !== 1'b1) begin
      n_fail++; $display("[TB] FAIL wrap_down: got %h/%b expected 9999/1", bcd_value, wrap);
    end
    do_load(16'h1000);
    n = 0;
    while (bcd_value == 16'h1000 && n < 3 * TDIV) begin @(negedge clk); n++; end
    n_checks++;
    if (bcd_value !== 16'h0999 || wrap !== 1'b0) begin
      n_fail++; $display("[TB] FAIL borrow_1000: got %h/%b expected 0999/0", bcd_value, wrap);
    end
  endtask

  task automatic test_load_priority();
    int n;
    up_down = 1'b1;
    do_load(16'hAF12);
    n_checks++;
    if (bcd_value !== 16'h9912) begin n_fail++; $display("[TB] FAIL load_clamp: got %h expected 9912", bcd_value); end
    n = 0;
    while (((m_edges + 1) % TDIV) != 0 && n < 2 * TDIV) begin @(negedge clk); n++; end
    load       = 1'b1;
    load_value = 16'h0123;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (bcd_value !== 16'h0123 || wrap !== 1'b0) begin
      n_fail++; $display("[TB] FAIL load_over_tick: got %h/%b expected 0123/0", bcd_value, wrap);
    end
    repeat (TDIV) @(negedge clk);
    n_checks++;
    if (bcd_value !== 16'h0124) begin n_fail++; $display("[TB] FAIL tick_after_load: got %h expected 0124", bcd_value); end
  endtask

  task automatic test_scan();
    int n;
    count_en = 1'b0;
    blank_lz = 1'b1;
    do_load(16'h0042);
    n = 0;
    while ((m_edges % SLOT) != 0 && n < 2 * SLOT) begin @(negedge clk); n++; end
    for (int c = 0; c < SLOT; c++) begin
      if (c > 0) @(negedge clk);
      n_checks++;
      if (c % RDIV == 0) begin
        if (anode !== 4'b1111 || led !== 7'h7F) begin
          n_fail++; $display("[TB] FAIL scan_dead c=%0d: got %b/%b expected 1111/1111111", c, anode, led);
        end
      end else if (anode !== EXP_AN[c / RDIV] || led !== EXP_LED[c / RDIV]) begin
        n_fail++;
        $display("[TB] FAIL scan_slot c=%0d: got %b/%b expected %b/%b", c, anode, led,
                 EXP_AN[c / RDIV], EXP_LED[c / RDIV]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      n_checks++;
      if (bcd_value !== to_bcd(m_val) || wrap !== m_wrap) begin
        n_fail++; $display("[TB] FAIL rand_value i=%0d: got %h/%b expected %h/%b", i, bcd_value, wrap, to_bcd(m_val), m_wrap);
      end
      n_checks++;
      if (anode !== m_anode || led !== m_led) begin
        n_fail++; $display("[TB] FAIL rand_display i=%0d: got %b/%b expected %b/%b", i, anode, led, m_anode, m_led);
      end
      count_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) up_down = ~up_down;
      if ($urandom_range(0, 29) == 0) blank_lz = ~blank_lz;
      load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       load_value = 16'h9998;
        1:       load_value = 16'h0001;
        default: load_value = 16'($urandom);
      endcase
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    count_en = 1'b1;
    up_down  = 1'b1;
    blank_lz = 1'b0;
    do_load(16'h5678);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (anode !== 4'b1111 || led !== 7'h7F) begin
      n_fail++; $display("[TB] FAIL async_reset_display: got %b/%b expected 1111/1111111", anode, led);
    end
    n_checks++;
    if (bcd_value !== 16'h0000 || wrap !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset_value: got %h/%b expected 0000/0", bcd_value, wrap);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= TDIV; i++) begin
      @(negedge clk);
      n_checks++;
      if (bcd_value !== ((i == TDIV) ? 16'h0001 : 16'h0000)) begin
        n_fail++; $display("[TB] FAIL restart_tick i=%0d: got %h expected %h", i, bcd_value, (i == TDIV) ? 16'h0001 : 16'h0000);
      end
      if (i == 1) begin
        n_checks++;
        if (anode !== 4'b0111 || led !== 7'b0000001) begin
          n_fail++; $display("[TB] FAIL restart_index: got %b/%b expected 0111/0000001", anode, led);
        end
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    count_en   = 1'b0;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = '0;
    blank_lz   = 1'b0;
    test_reset();
    test_count_up();
    test_carry_wrap();
    test_borrow();
    test_load_priority();
    test_scan();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
